// File: rtl/hd44780_frame_driver.sv
`default_nettype none
// ============================================================================
// Module  : hd44780_frame_driver
// Brief   : ROWS x COLS frame-buffered HD44780/ST7066 driver with power-on init
//           and RS/E/data timing on an 8-bit or 4-bit bus.
//           Optional build macro DIRTY_ROW_EN: refresh only rows written since
//           they were last sent.
// Revision: 1.0 - initial release
// ============================================================================
module hd44780_frame_driver #(
   parameter int ROWS        = 2,
   parameter int COLS        = 16,
   parameter int BUS_WIDTH   = 8,
   parameter int T_SETUP_CYC = 4,
   parameter int T_E_CYC     = 50,
   parameter int T_CMD_CYC   = 4000,
   parameter int T_LONG_CYC  = 160000,
   parameter int T_POR_CYC   = 4000000
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_wr_en,
   input  logic [6:0] i_wr_addr,
   input  logic [7:0] i_wr_data,
   input  logic       i_refresh,
   output logic       o_ready,
   output logic       o_busy,
   output logic       o_rs,
   output logic       o_e,
   output logic [7:0] o_d
);
   localparam int DEPTH    = ROWS * COLS;
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int INIT_LEN = (BUS_WIDTH == 4) ? 8 : 7;

   typedef enum logic [1:0] {S_POR_WAIT, S_INIT, S_IDLE, S_REFRESH} main_state_t;
   typedef enum logic [2:0] {X_IDLE, X_SETUP, X_E_HI, X_HOLD, X_WAIT} tx_state_t;

   main_state_t   r_state, w_state_next;
   tx_state_t     r_tx_state, w_tx_next;

   logic [7:0]    r_buf [0:(1<<AW)-1];
   logic [AW-1:0] w_rd_addr;
   logic [7:0]    w_rd_data;

   logic [31:0]   r_cnt, w_cnt_next;
   logic [7:0]    r_tx_byte, w_lat_byte;
   logic          r_tx_rs, w_lat_rs;
   logic          r_tx_single, w_lat_single;
   logic          r_tx_low, w_lat_low;
   logic          w_tx_ready;
   logic [7:0]    w_d_next;
   logic          r_e, r_rs;
   logic [7:0]    r_d;

   logic          w_tx_start;
   logic [7:0]    w_req_byte;
   logic          w_req_rs, w_req_single;

   logic [31:0]   r_por_cnt, w_por_next;
   logic [3:0]    r_step, w_step_next;
   logic [2:0]    r_row, w_row_next, w_scan_row;
   logic [5:0]    r_col, w_col_next;
   logic          r_phase, w_phase_next;
   logic          r_pending, r_busy, r_ready;

   function automatic logic [8:0] init_entry(input logic [3:0] step);
      // {nibble_only, byte}
      logic [8:0] v;
      v = 9'h006;
      if (BUS_WIDTH == 4) begin
         case (step)
            4'd0, 4'd1, 4'd2: v = 9'h130;
            4'd3:             v = 9'h120;
            4'd4:             v = 9'h028;
            4'd5:             v = 9'h00C;
            4'd6:             v = 9'h001;
            default:          v = 9'h006;
         endcase
      end else begin
         case (step)
            4'd0, 4'd1, 4'd2: v = 9'h030;
            4'd3:             v = 9'h038;
            4'd4:             v = 9'h00C;
            4'd5:             v = 9'h001;
            default:          v = 9'h006;
         endcase
      end
      return v;
   endfunction

   function automatic logic [7:0] row_cmd(input logic [2:0] row);
      case (row)
         3'd1:    return 8'hC0;
         3'd2:    return 8'h94;
         3'd3:    return 8'hD4;
         default: return 8'h80;
      endcase
   endfunction

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < (1<<AW); i++) r_buf[i] <= 8'h20;
      end else if (i_wr_en && (i_wr_addr < 7'(DEPTH))) begin
         r_buf[i_wr_addr[AW-1:0]] <= i_wr_data;
      end
   end

   assign w_rd_addr = AW'(r_row) * AW'(COLS) + AW'(r_col);
   assign w_rd_data = r_buf[w_rd_addr];

   // The engine accepts a new byte in its last WAIT cycle so bytes run back to back.
   assign w_tx_ready = (r_tx_state == X_IDLE) || ((r_tx_state == X_WAIT) && (r_cnt == 32'd0));

   always_comb begin
      w_tx_next    = r_tx_state;
      w_cnt_next   = r_cnt;
      w_lat_byte   = r_tx_byte;
      w_lat_rs     = r_tx_rs;
      w_lat_single = r_tx_single;
      w_lat_low    = r_tx_low;
      case (r_tx_state)
         X_SETUP: begin
            if (r_cnt == 32'd0) begin
               w_tx_next  = X_E_HI;
               w_cnt_next = 32'(T_E_CYC - 1);
            end else w_cnt_next = r_cnt - 32'd1;
         end
         X_E_HI: begin
            if (r_cnt == 32'd0) begin
               w_tx_next  = X_HOLD;
               w_cnt_next = 32'(T_SETUP_CYC - 1);
            end else w_cnt_next = r_cnt - 32'd1;
         end
         X_HOLD: begin
            if (r_cnt == 32'd0) begin
               if ((BUS_WIDTH == 4) && !r_tx_low && !r_tx_single) begin
                  w_tx_next  = X_SETUP;
                  w_lat_low  = 1'b1;
                  w_cnt_next = 32'(T_SETUP_CYC - 1);
               end else begin
                  w_tx_next  = X_WAIT;
                  w_cnt_next = ((r_tx_byte == 8'h01) && !r_tx_rs) ?
                               32'(T_LONG_CYC - 1) : 32'(T_CMD_CYC - 1);
               end
            end else w_cnt_next = r_cnt - 32'd1;
         end
         X_WAIT: begin
            if (r_cnt == 32'd0) w_tx_next = X_IDLE;
            else                w_cnt_next = r_cnt - 32'd1;
         end
         default: ;
      endcase
      if (w_tx_ready && w_tx_start) begin
         w_tx_next    = X_SETUP;
         w_cnt_next   = 32'(T_SETUP_CYC - 1);
         w_lat_byte   = w_req_byte;
         w_lat_rs     = w_req_rs;
         w_lat_single = w_req_single;
         w_lat_low    = 1'b0;
      end
   end

   generate
      if (BUS_WIDTH == 4) begin : g_bus4
         assign w_d_next = {(w_lat_low ? w_lat_byte[3:0] : w_lat_byte[7:4]), 4'h0};
      end else begin : g_bus8
         assign w_d_next = w_lat_byte;
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_tx_state  <= X_IDLE;
         r_cnt       <= 32'd0;
         r_tx_byte   <= 8'h00;
         r_tx_rs     <= 1'b0;
         r_tx_single <= 1'b0;
         r_tx_low    <= 1'b0;
         r_e         <= 1'b0;
         r_rs        <= 1'b0;
         r_d         <= 8'h00;
      end else begin
         r_tx_state  <= w_tx_next;
         r_cnt       <= w_cnt_next;
         r_tx_byte   <= w_lat_byte;
         r_tx_rs     <= w_lat_rs;
         r_tx_single <= w_lat_single;
         r_tx_low    <= w_lat_low;
         r_e         <= (w_tx_next == X_E_HI);
         r_rs        <= w_lat_rs;
         r_d         <= w_d_next;
      end
   end

`ifdef DIRTY_ROW_EN
   logic [ROWS-1:0] r_dirty;
   logic            w_hdr_issue;

   // Lowest dirty row at or after r_row; ROWS when nothing is left to send.
   always_comb begin
      w_scan_row = 3'(ROWS);
      for (int r = ROWS - 1; r >= 0; r--) begin
         if ((3'(r) >= r_row) && r_dirty[r]) w_scan_row = 3'(r);
      end
   end

   assign w_hdr_issue = (r_state == S_REFRESH) && w_tx_ready && !r_phase &&
                        (w_scan_row < 3'(ROWS));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_dirty <= '1;
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (w_hdr_issue && (w_scan_row == 3'(r))) r_dirty[r] <= 1'b0;
            // a write in the same cycle as the header wins so it is never lost
            if (i_wr_en && (i_wr_addr >= 7'(r * COLS)) && (i_wr_addr < 7'((r + 1) * COLS)))
               r_dirty[r] <= 1'b1;
         end
      end
   end
`else
   assign w_scan_row = r_row;
`endif

   always_comb begin
      w_state_next = r_state;
      w_por_next   = r_por_cnt;
      w_step_next  = r_step;
      w_row_next   = r_row;
      w_col_next   = r_col;
      w_phase_next = r_phase;
      w_tx_start   = 1'b0;
      w_req_byte   = 8'h00;
      w_req_rs     = 1'b0;
      w_req_single = 1'b0;
      case (r_state)
         S_POR_WAIT: begin
            if (r_por_cnt == 32'd0) begin
               w_state_next = S_INIT;
               w_step_next  = 4'd0;
            end else w_por_next = r_por_cnt - 32'd1;
         end
         S_INIT: begin
            if (w_tx_ready) begin
               if (r_step == 4'(INIT_LEN)) begin
                  w_state_next = S_IDLE;
               end else begin
                  w_tx_start   = 1'b1;
                  w_req_byte   = init_entry(r_step)[7:0];
                  w_req_single = init_entry(r_step)[8];
                  w_step_next  = r_step + 4'd1;
               end
            end
         end
         S_IDLE: begin
            if (i_refresh || r_pending) begin
               w_state_next = S_REFRESH;
               w_row_next   = 3'd0;
               w_col_next   = 6'd0;
               w_phase_next = 1'b0;
            end
         end
         S_REFRESH: begin
            if (w_tx_ready) begin
               if (!r_phase) begin
                  if (w_scan_row >= 3'(ROWS)) begin
                     w_state_next = S_IDLE;
                  end else begin
                     w_tx_start   = 1'b1;
                     w_req_byte   = row_cmd(w_scan_row);
                     w_row_next   = w_scan_row;
                     w_col_next   = 6'd0;
                     w_phase_next = 1'b1;
                  end
               end else begin
                  w_tx_start = 1'b1;
                  w_req_rs   = 1'b1;
                  w_req_byte = w_rd_data;
                  if (r_col == 6'(COLS - 1)) begin
                     w_phase_next = 1'b0;
                     w_row_next   = r_row + 3'd1;
                  end else w_col_next = r_col + 6'd1;
               end
            end
         end
         default: w_state_next = S_POR_WAIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= S_POR_WAIT;
         r_por_cnt <= 32'(T_POR_CYC - 1);
         r_step    <= 4'd0;
         r_row     <= 3'd0;
         r_col     <= 6'd0;
         r_phase   <= 1'b0;
         r_pending <= 1'b0;
         r_busy    <= 1'b1;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_por_cnt <= w_por_next;
         r_step    <= w_step_next;
         r_row     <= w_row_next;
         r_col     <= w_col_next;
         r_phase   <= w_phase_next;
         r_busy    <= (w_state_next != S_IDLE);
         if ((r_state == S_INIT) && (w_state_next == S_IDLE)) r_ready <= 1'b1;
         // IDLE services any request at once, so the flag only matters while busy
         if (r_state == S_IDLE) r_pending <= 1'b0;
         else if (i_refresh)    r_pending <= 1'b1;
      end
   end

   assign o_ready = r_ready;
   assign o_busy  = r_busy;
   assign o_rs    = r_rs;
   assign o_e     = r_e;
   assign o_d     = r_d;

endmodule
`default_nettype wire

// File: tb/tb_hd44780_frame_driver.sv
`default_nettype none
// Directed bench for hd44780_frame_driver: an 8-bit 2x4 instance and a 4-bit 1x1
// instance with short timing; E-latched bytes are captured and compared to tables.
module tb_hd44780_frame_driver;
   localparam int TS = 1, TE = 2, TC = 5, TL = 10, TP = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       wr8 = 1'b0, rf8 = 1'b0, wr4 = 1'b0, rf4 = 1'b0;
   logic [6:0] wa8 = 7'd0, wa4 = 7'd0;
   logic [7:0] wd8 = 8'd0, wd4 = 8'd0;
   logic       ready8, busy8, rs8, e8, ready4, busy4, rs4, e4;
   logic [7:0] d8, d4;

   hd44780_frame_driver #(.ROWS(2), .COLS(4), .BUS_WIDTH(8), .T_SETUP_CYC(TS), .T_E_CYC(TE),
      .T_CMD_CYC(TC), .T_LONG_CYC(TL), .T_POR_CYC(TP)) u_dut8 (
      .i_clk(clk), .i_reset_n(rst_n), .i_wr_en(wr8), .i_wr_addr(wa8), .i_wr_data(wd8),
      .i_refresh(rf8), .o_ready(ready8), .o_busy(busy8), .o_rs(rs8), .o_e(e8), .o_d(d8));

   hd44780_frame_driver #(.ROWS(1), .COLS(1), .BUS_WIDTH(4), .T_SETUP_CYC(TS), .T_E_CYC(TE),
      .T_CMD_CYC(TC), .T_LONG_CYC(TL), .T_POR_CYC(TP)) u_dut4 (
      .i_clk(clk), .i_reset_n(rst_n), .i_wr_en(wr4), .i_wr_addr(wa4), .i_wr_data(wd4),
      .i_refresh(rf4), .o_ready(ready4), .o_busy(busy4), .o_rs(rs4), .o_e(e4), .o_d(d4));

   int checks = 0, failures = 0;
   int cyc = 0, rel_cyc = 0;
   logic [8:0] q8[$], q4[$];
   int w8[$], w4[$], rise8[$], fall8[$];
   int hold_err8 = 0, hold_err4 = 0, rc8 = 0, rc4 = 0;
   logic pe8 = 1'b0, pe4 = 1'b0;
   logic [8:0] cur8 = 9'd0, cur4 = 9'd0;

   // capture {rs,d} at each E rise, pulse width at each fall, and any change while E is high
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (e8 && !pe8) begin
         cur8 = {rs8, d8}; q8.push_back(cur8); rise8.push_back(cyc); rc8 = cyc;
      end else if (e8 && ({rs8, d8} !== cur8)) hold_err8++;
      if (!e8 && pe8) begin w8.push_back(cyc - rc8); fall8.push_back(cyc); end
      pe8 = e8;
      if (e4 && !pe4) begin
         cur4 = {rs4, d4}; q4.push_back(cur4); rc4 = cyc;
      end else if (e4 && ({rs4, d4} !== cur4)) hold_err4++;
      if (!e4 && pe4) w4.push_back(cyc - rc4);
      pe4 = e4;
   end

   task automatic clear_q();
      q8.delete(); w8.delete(); rise8.delete(); fall8.delete(); q4.delete(); w4.delete();
   endtask

   task automatic pulse8();
      @(posedge clk); #1 rf8 = 1'b1;
      @(posedge clk); #1 rf8 = 1'b0;
   endtask

   task automatic write8(input logic [6:0] a, input logic [7:0] d);
      @(posedge clk); #1 wr8 = 1'b1; wa8 = a; wd8 = d;
      @(posedge clk); #1 wr8 = 1'b0;
   endtask

   task automatic wait_frame8(input string name);
      int n;
      n = 0;
      while (busy8 !== 1'b1 && n < 20)   begin @(negedge clk); n++; end
      while (busy8 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      checks++;
      if (busy8 !== 1'b0) begin
         failures++; $display("FAIL %s_timeout busy=%b required 0", name, busy8);
      end
   endtask

   task automatic check_frame8(input string name, input logic [8:0] exp[$]);
      logic [8:0] got;
      checks++;
      if (q8.size() != exp.size()) begin
         failures++; $display("FAIL %s_count got=%0d required=%0d", name, q8.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q8.size()) ? q8[i] : 9'h1FF;
         checks++;
         if (got !== exp[i]) begin
            failures++; $display("FAIL %s[%0d] got=%h required=%h", name, i, got, exp[i]);
         end
         if (i < w8.size()) begin
            checks++;
            if (w8[i] != TE) begin
               failures++; $display("FAIL %s_ewidth[%0d] got=%0d required=%0d", name, i, w8[i], TE);
            end
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({e8, rs8, d8, ready8, busy8} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
         failures++; $display("FAIL reset8 got e=%b rs=%b d=%h rdy=%b busy=%b required 0 0 00 0 1",
                              e8, rs8, d8, ready8, busy8);
      end
      checks++;
      if ({e4, d4, ready4, busy4} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
         failures++; $display("FAIL reset4 got e=%b d=%h rdy=%b busy=%b required 0 00 0 1",
                              e4, d4, ready4, busy4);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_init8();
      logic [8:0] exp[$] = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h00C, 9'h001, 9'h006};
      int n;
      n = 0;
      while (ready8 !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (ready8 !== 1'b1 || busy8 !== 1'b0) begin
         failures++; $display("FAIL init8_ready got rdy=%b busy=%b required 1 0", ready8, busy8);
      end
      check_frame8("init8", exp);
      checks++;
      if (rise8.size() >= 7 && (rise8[6] - fall8[5]) != (2*TS + TL)) begin
         failures++; $display("FAIL gap_after_clear got=%0d required=%0d", rise8[6] - fall8[5], 2*TS + TL);
      end
      checks++;
      if (rise8.size() >= 7 && (rise8[5] - fall8[4]) != (2*TS + TC)) begin
         failures++; $display("FAIL gap_after_cmd got=%0d required=%0d", rise8[5] - fall8[4], 2*TS + TC);
      end
   endtask

   task automatic test_init4();
      logic [8:0] exp[$] = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h020, 9'h080,
                             9'h000, 9'h0C0, 9'h000, 9'h010, 9'h000, 9'h060};
      logic [8:0] got;
      int n;
      n = 0;
      while (ready4 !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (ready4 !== 1'b1 || q4.size() != exp.size()) begin
         failures++; $display("FAIL init4_ready got rdy=%b count=%0d required 1 %0d", ready4, q4.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q4.size()) ? q4[i] : 9'h1FF;
         checks++;
         if (got !== exp[i]) begin
            failures++; $display("FAIL init4[%0d] got=%h required=%h", i, got, exp[i]);
         end
      end
   endtask

   task automatic test_refresh8();
      logic [8:0] exp[$] = '{9'h080, 9'h141, 9'h142, 9'h143, 9'h144,
                             9'h0C0, 9'h131, 9'h132, 9'h133, 9'h134};
      logic [7:0] txt[8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h31, 8'h32, 8'h33, 8'h34};
      clear_q();
      for (int i = 0; i < 8; i++) write8(7'(i), txt[i]);
      pulse8();
      wait_frame8("refresh8");
      check_frame8("refresh8", exp);
   endtask

   task automatic test_refresh4();
      logic [8:0] exp[$] = '{9'h080, 9'h000, 9'h140, 9'h110};
      logic [8:0] got;
      int n;
      clear_q();
      @(posedge clk); #1 wr4 = 1'b1; wa4 = 7'd0; wd4 = 8'h41;
      @(posedge clk); #1 wr4 = 1'b0; rf4 = 1'b1;
      @(posedge clk); #1 rf4 = 1'b0;
      n = 0;
      while (busy4 !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (busy4 !== 1'b0 || q4.size() != exp.size()) begin
         failures++; $display("FAIL refresh4_done got busy=%b count=%0d required 0 %0d", busy4, q4.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q4.size()) ? q4[i] : 9'h1FF;
         checks++;
         if (got !== exp[i]) begin
            failures++; $display("FAIL refresh4[%0d] got=%h required=%h", i, got, exp[i]);
         end
      end
      checks++;
      if (hold_err4 != 0 || hold_err8 != 0) begin
         failures++; $display("FAIL bus_stable_during_e got=%0d/%0d required 0/0", hold_err8, hold_err4);
      end
   endtask

   task automatic test_pending();
      logic [8:0] exp[$];
      logic [8:0] fr[10] = '{9'h080, 9'h141, 9'h142, 9'h143, 9'h144,
                             9'h0C0, 9'h131, 9'h132, 9'h133, 9'h134};
      logic [7:0] txt[8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h31, 8'h32, 8'h33, 8'h34};
      int n;
      for (int i = 0; i < 20; i++) exp.push_back(fr[i % 10]);
      clear_q();
      pulse8();
      n = 0;
      while (q8.size() < 6 && n < 500) begin @(negedge clk); n++; end
      // identical rewrite keeps both rows marked for the next frame in every build
      for (int i = 0; i < 8; i++) write8(7'(i), txt[i]);
      write8(7'd8, 8'h5A);
      for (int k = 0; k < 3; k++) begin pulse8(); @(posedge clk); end
      n = 0;
      while (q8.size() < 20 && n < 2000) begin @(negedge clk); n++; end
      repeat (200) @(negedge clk);
      checks++;
      if (busy8 !== 1'b0) begin
         failures++; $display("FAIL pending_idle got busy=%b required 0", busy8);
      end
      check_frame8("pending", exp);
   endtask

`ifdef DIRTY_ROW_EN
   task automatic test_dirty();
      logic [8:0] exp[$] = '{9'h0C0, 9'h158, 9'h132, 9'h133, 9'h134};
      clear_q();
      write8(7'd4, 8'h58);
      pulse8();
      wait_frame8("dirty");
      check_frame8("dirty", exp);
      clear_q();
      pulse8();
      repeat (3) @(negedge clk);
      checks++;
      if (busy8 !== 1'b0) begin
         failures++; $display("FAIL clean_refresh_busy got=%b required 0", busy8);
      end
      repeat (30) @(negedge clk);
      checks++;
      if (q8.size() != 0) begin
         failures++; $display("FAIL clean_refresh_epulses got=%0d required 0", q8.size());
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic [8:0] exp[$] = '{9'h080, 9'h120, 9'h120, 9'h120, 9'h120,
                             9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120};
      int n;
      pulse8();
      n = 0;
      while (e8 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (e8 !== 1'b1) begin
         failures++; $display("FAIL mid_e_seen got=%b required 1", e8);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({e8, rs8, d8, ready8, busy8} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
         failures++; $display("FAIL mid_reset got e=%b rs=%b d=%h rdy=%b busy=%b required 0 0 00 0 1",
                              e8, rs8, d8, ready8, busy8);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      rel_cyc = cyc;
      clear_q();
      repeat (TP/2) @(negedge clk);
      checks++;
      if (busy8 !== 1'b1 || q8.size() != 0) begin
         failures++; $display("FAIL por_restart got busy=%b pulses=%0d required 1 0", busy8, q8.size());
      end
      n = 0;
      while (ready8 !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (rise8.size() == 0 || (rise8[0] - rel_cyc) < TP || (rise8[0] - rel_cyc) > TP + TS + 4) begin
         failures++; $display("FAIL por_first_e got=%0d required %0d..%0d",
                              (rise8.size() > 0) ? rise8[0] - rel_cyc : -1, TP, TP + TS + 4);
      end
      clear_q();
      pulse8();
      wait_frame8("post_reset");
      check_frame8("post_reset", exp);
   endtask

   initial begin
      test_reset();
      test_init8();
      test_init4();
      test_refresh8();
      test_refresh4();
      test_pending();
`ifdef DIRTY_ROW_EN
      test_dirty();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
